random_tile_placer: RTL and testbench

- Consumer end of the random-number generator interface.
- Pulses the generator's request line and captures the random value it latches.
- Uses captured values to place NUM_TILES obstacle tiles into the game map RAM through a write port.
- Clears the map first, rejects illegal or duplicate positions, and reports completion to the game-control FSM at level start.

---
 rtl/random_tile_placer.sv | 153 +++++++++++++++
 tb/tb_random_tile_placer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/random_tile_placer.sv
// Places NUM_TILES obstacle tiles into the map RAM from generator samples.
// Clears the map first and rejects spawn/base-row and already-occupied positions.
module random_tile_placer #(
   parameter int SIZE_BITS    = 8,
   parameter int COLS_LOG2    = 4,
   parameter int NUM_TILES    = 40,
   parameter int MAX_TRIES    = 1000,
   parameter int STEEL_THRESH = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [SIZE_BITS-1:0] rnd_in,
   output logic                 rnd_req,
   output logic                 wr_en,
   output logic [SIZE_BITS-1:0] wr_addr,
   output logic [1:0]           wr_data,
   output logic                 busy,
   output logic                 done,
   output logic                 fail,
   output logic [SIZE_BITS-1:0] placed_count,
   output logic [15:0]          reject_count
);

   localparam int NMAP     = 2 ** SIZE_BITS;
   localparam int ROW_BITS = SIZE_BITS - COLS_LOG2;

   typedef enum logic [3:0] {
      IDLE, CLEAR, REQ_A, CAP_A, CHK_A, REQ_T, CAP_T, WRITE, DONE
   } state_t;

   state_t               state_q, state_d;
   logic [SIZE_BITS-1:0] clr_q, clr_d;
   logic [SIZE_BITS-1:0] addr_q, addr_d;
   logic [1:0]           type_q, type_d;
   logic                 fail_q, fail_d;
   logic [SIZE_BITS-1:0] placed_q, placed_d;
   logic [15:0]          rej_q, rej_d;
   logic [NMAP-1:0]      occ_q;

   logic [ROW_BITS-1:0]  row;
   logic                 reject;
   logic [15:0]          rej_inc;
   logic [SIZE_BITS-1:0] placed_inc;

   assign row        = addr_q[SIZE_BITS-1:COLS_LOG2];
   assign reject     = (row == '0) || (row == '1) || occ_q[addr_q];
   assign rej_inc    = rej_q + 16'd1;
   assign placed_inc = placed_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         clr_q    <= '0;
         addr_q   <= '0;
         type_q   <= '0;
         fail_q   <= 1'b0;
         placed_q <= '0;
         rej_q    <= '0;
      end else begin
         state_q  <= state_d;
         clr_q    <= clr_d;
         addr_q   <= addr_d;
         type_q   <= type_d;
         fail_q   <= fail_d;
         placed_q <= placed_d;
         rej_q    <= rej_d;
      end
   end

   // Occupancy has no reset; every run rebuilds it during CLEAR.
   always_ff @(posedge clk) begin
      if (state_q == CLEAR)
         occ_q[clr_q] <= 1'b0;
      else if (state_q == CHK_A && !reject)
         occ_q[addr_q] <= 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      clr_d    = clr_q;
      addr_d   = addr_q;
      type_d   = type_q;
      fail_d   = fail_q;
      placed_d = placed_q;
      rej_d    = rej_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = CLEAR;
               clr_d    = '0;
               fail_d   = 1'b0;
               placed_d = '0;
               rej_d    = '0;
            end
         end
         CLEAR: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == '1)
               state_d = REQ_A;
         end
         REQ_A: state_d = CAP_A;
         CAP_A: begin
            addr_d  = rnd_in;
            state_d = CHK_A;
         end
         CHK_A: begin
            if (reject) begin
               rej_d = rej_inc;
               if (rej_inc == 16'(MAX_TRIES)) begin
                  fail_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = REQ_A;
               end
            end else begin
               state_d = REQ_T;
            end
         end
         REQ_T: state_d = CAP_T;
         CAP_T: begin
            type_d  = (int'(rnd_in) < STEEL_THRESH) ? 2'd2 : 2'd1;
            state_d = WRITE;
         end
         WRITE: begin
            placed_d = placed_inc;
            state_d  = (placed_inc == SIZE_BITS'(NUM_TILES)) ? DONE : REQ_A;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rnd_req = (state_q == REQ_A) || (state_q == REQ_T);
      wr_en   = (state_q == CLEAR) || (state_q == WRITE);
      wr_addr = '0;
      wr_data = 2'd0;
      if (state_q == CLEAR) begin
         wr_addr = clr_q;
      end else if (state_q == WRITE) begin
         wr_addr = addr_q;
         wr_data = type_q;
      end
      done = (state_q == DONE);
      busy = (state_q != IDLE) && (state_q != DONE);
   end

   assign fail         = fail_q;
   assign placed_count = placed_q;
   assign reject_count = rej_q;

endmodule

// File: tb/tb_random_tile_placer.sv
// Scoreboard bench for random_tile_placer with a scripted random-number generator.
module tb_random_tile_placer;

   logic        clk, reset, start;
   logic [7:0]  rnd_in;
   logic        rnd_req, wr_en, busy, done, fail;
   logic [7:0]  wr_addr, placed_count;
   logic [1:0]  wr_data;
   logic [15:0] reject_count;

   random_tile_placer #(
      .SIZE_BITS(8), .COLS_LOG2(4), .NUM_TILES(3), .MAX_TRIES(5), .STEEL_THRESH(64)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .rnd_in(rnd_in),
      .rnd_req(rnd_req), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .fail(fail),
      .placed_count(placed_count), .reject_count(reject_count)
   );

   typedef struct {
      bit          is_done;
      logic [7:0]  addr;
      logic [1:0]  data;
      logic [7:0]  placed;
      logic [15:0] rej;
      logic        fl;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] gen_q[$];
   int         req_cyc[$];
   int         tests = 0, fails = 0;
   int         cyc = 0, last_clr_cyc = 0, last_tile_cyc = 0, done_cyc = 0;
   int         gen_underflow = 0;
   logic       prev_req = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Generator stub: latches the next scripted value on each request pulse.
   initial forever begin
      @(negedge clk);
      if (rnd_req) begin
         if (gen_q.size() > 0) rnd_in = gen_q.pop_front();
         else begin
            rnd_in = 8'hAA;
            gen_underflow++;
         end
      end
   end

   // Monitor: pops one expectation per write strobe or done pulse.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset) prev_req = 1'b0;
      else begin
         if (rnd_req) begin
            check("req_back_to_back", prev_req, 0);
            req_cyc.push_back(cyc);
         end
         prev_req = rnd_req;
         if (wr_en || done) begin
            if (exp_q.size() == 0) check("unexpected_output", {wr_en, done, wr_addr}, 0);
            else begin
               e = exp_q.pop_front();
               if (!e.is_done) begin
                  check("wr_en", {wr_en, done}, 2'b10);
                  check("wr_addr", wr_addr, e.addr);
                  check("wr_data", wr_data, e.data);
                  check("reject_at_write", reject_count, e.rej);
                  if (wr_addr == 8'hFF && wr_data == 2'd0) last_clr_cyc = cyc;
                  if (wr_data != 2'd0) last_tile_cyc = cyc;
               end else begin
                  check("done_pulse", {wr_en, done, busy}, 3'b010);
                  check("placed_at_done", placed_count, e.placed);
                  check("reject_at_done", reject_count, e.rej);
                  check("fail_at_done", fail, e.fl);
                  done_cyc = cyc;
               end
            end
         end
      end
   end

   task automatic push_clear();
      for (int i = 0; i < 256; i++) exp_q.push_back('{0, 8'(i), 2'd0, 8'd0, 16'd0, 1'b0});
   endtask

   task automatic push_wr(input logic [7:0] a, input logic [1:0] d, input logic [15:0] r);
      exp_q.push_back('{0, a, d, 8'd0, r, 1'b0});
   endtask

   task automatic push_done(input logic [7:0] p, input logic [15:0] r, input logic f);
      exp_q.push_back('{1, 8'd0, 2'd0, p, r, f});
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < limit);
      check("done_seen", done, 1);
   endtask

   initial begin
      int offs[9] = '{0, 3, 6, 9, 12, 15, 18, 21, 24};
      int n;
      reset = 1'b1; start = 1'b0; rnd_in = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_outputs", {rnd_req, wr_en, wr_addr, wr_data, busy, done, fail,
                              placed_count, reject_count}, 0);
      reset = 1'b0;
      @(negedge clk);

      // Run 1: row-0 reject, duplicate, base-row reject, 0x40 type boundary.
      gen_q = '{8'h05, 8'h25, 8'h10, 8'h25, 8'hB3, 8'h80, 8'hF7, 8'h47, 8'h40};
      push_clear();
      push_wr(8'h25, 2'd2, 16'd1);
      push_wr(8'hB3, 2'd1, 16'd2);
      push_wr(8'h47, 2'd1, 16'd3);
      push_done(8'd3, 16'd3, 1'b0);
      req_cyc.delete();
      do_start();
      wait_done(2000);
      @(negedge clk);
      check("run1_idle_busy", busy, 0);
      check("run1_placed_held", placed_count, 3);
      check("run1_req_count", req_cyc.size(), 9);
      if (req_cyc.size() == 9) begin
         check("first_req_after_clear", req_cyc[0] - last_clr_cyc, 1);
         for (int i = 1; i < 9; i++) check("req_spacing", req_cyc[i] - req_cyc[0], offs[i]);
      end
      check("done_after_last_write", done_cyc - last_tile_cyc, 1);
      check("run1_scoreboard_empty", exp_q.size(), 0);
      check("run1_gen_used", gen_q.size() + gen_underflow, 0);

      // Run 2: every sample in row 0 exhausts MAX_TRIES.
      gen_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      push_clear();
      push_done(8'd0, 16'd5, 1'b1);
      do_start();
      wait_done(2000);
      repeat (3) @(negedge clk);
      check("fail_held", {fail, busy, reject_count}, {1'b1, 1'b0, 16'd5});
      check("run2_scoreboard_empty", exp_q.size(), 0);
      check("run2_gen_used", gen_q.size() + gen_underflow, 0);

      // Run 3: one tile (0x3F type -> steel), then reset during CAP_T of the second.
      gen_q = '{8'h34, 8'h3F, 8'h35, 8'h99};
      push_clear();
      push_wr(8'h34, 2'd2, 16'd0);
      do_start();
      n = 0;
      for (int k = 0; k < 2000 && n < 4; k++) begin
         @(negedge clk);
         if (rnd_req) n++;
      end
      check("run3_req_pulses", n, 4);
      @(negedge clk);
      check("pre_reset_placed", placed_count, 1);
      reset = 1'b1;
      @(negedge clk);
      check("midrun_reset_outputs", {rnd_req, wr_en, wr_addr, wr_data, busy, done, fail,
                                     placed_count, reject_count}, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("stays_idle", {busy, wr_en, rnd_req}, 0);
      check("run3_scoreboard_empty", exp_q.size(), 0);

      // Run 4: full clear again; reused positions must be accepted.
      gen_q = '{8'h35, 8'h00, 8'h34, 8'hFF, 8'h5A, 8'h3F};
      push_clear();
      push_wr(8'h35, 2'd2, 16'd0);
      push_wr(8'h34, 2'd1, 16'd0);
      push_wr(8'h5A, 2'd2, 16'd0);
      push_done(8'd3, 16'd0, 1'b0);
      do_start();
      wait_done(2000);
      @(negedge clk);
      check("run4_scoreboard_empty", exp_q.size(), 0);
      check("run4_gen_used", gen_q.size() + gen_underflow, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
